// File: rtl/apb_master_bridge_if.sv
// Bundles the command, response and APB signals of apb_master_bridge.
// The master modport is the bridge's view; slave is the surrounding environment.
interface apb_master_bridge_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic [ADDR_W-1:0] paddr;
   logic              pwrite;
   logic              psel;
   logic              penable;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, psel, penable, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, psel, penable, pwdata
   );
endinterface

// File: rtl/apb_master_bridge.sv
// Converts valid/ready commands into APB3 SETUP/ACCESS transfers and returns
// each result on a valid/ready response port, aborting stalled slaves via a watchdog.
module apb_master_bridge #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input logic                 clk,
   input logic                 resetn,
   apb_master_bridge_if.master bus
);
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [WD_W-1:0] wdog;
   logic            timeout_hit;

   // wdog counts completed ACCESS cycles without pready; the last allowed one is ending now.
   assign timeout_hit = (wdog == WD_LAST);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      bus.cmd_ready = 1'b0;
      bus.psel      = 1'b0;
      bus.penable   = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            bus.psel   = 1'b1;
            state_next = ACCESS;
         end
         ACCESS: begin
            bus.psel    = 1'b1;
            bus.penable = 1'b1;
            if (bus.pready || timeout_hit) begin
               state_next = RESP;
            end
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // pready is checked before the timeout so a late-but-valid reply is never reported as an error.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.paddr     <= {ADDR_W{1'b0}};
         bus.pwrite    <= 1'b0;
         bus.pwdata    <= {DATA_W{1'b0}};
         bus.rsp_rdata <= {DATA_W{1'b0}};
         bus.rsp_err   <= 1'b0;
         wdog          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.paddr  <= bus.cmd_addr;
                  bus.pwrite <= bus.cmd_write;
                  bus.pwdata <= bus.cmd_wdata;
               end
            end
            SETUP: begin
               wdog <= '0;
            end
            ACCESS: begin
               if (bus.pready) begin
                  bus.rsp_rdata <= bus.pwrite ? {DATA_W{1'b0}} : bus.prdata;
                  bus.rsp_err   <= 1'b0;
               end else begin
                  if (wdog != WD_MAX) begin
                     wdog <= wdog + WD_W'(1);
                  end
                  if (timeout_hit) begin
                     bus.rsp_rdata <= {DATA_W{1'b0}};
                     bus.rsp_err   <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge: a wait-state APB slave plus a
// transaction-level model predicting each response, its latency and its ACCESS length.
module tb_apb_master_bridge;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 16;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   apb_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.master)
   );

   int checks = 0;
   int failures = 0;

   logic [7:0] slave_mem [256];
   logic [7:0] model_mem [256];

   int         wait_cfg = 0;
   int         acc_cnt = 0;
   bit         was_access = 1'b0;
   bit         pend_wr = 1'b0;
   logic [7:0] pend_addr = 8'h00;
   logic [7:0] pend_data = 8'h00;

   int          viol = 0;
   bit          prev_psel = 1'b0;
   logic [16:0] setup_log [$];
   logic [8:0]  rsp_log [$];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #2;
   endtask

   // Slave: ready after wait_cfg stalled ACCESS cycles (never if negative); noise outside ACCESS.
   always @(posedge clk) begin
      #1;
      if (!resetn) begin
         acc_cnt    = 0;
         was_access = 1'b0;
         pend_wr    = 1'b0;
         bus.pready = 1'b0;
      end else begin
         if (pend_wr) slave_mem[pend_addr] = pend_data;
         pend_wr = 1'b0;
         if (bus.psel && bus.penable) begin
            acc_cnt    = was_access ? acc_cnt + 1 : 0;
            was_access = 1'b1;
            bus.pready = (wait_cfg >= 0) && (acc_cnt >= wait_cfg);
            bus.prdata = slave_mem[bus.paddr];
            if (bus.pready && bus.pwrite) begin
               pend_wr   = 1'b1;
               pend_addr = bus.paddr;
               pend_data = bus.pwdata;
            end
         end else begin
            was_access = 1'b0;
            bus.pready = 1'($urandom_range(0, 1));
            bus.prdata = 8'($urandom);
         end
      end
   end

   always @(negedge clk) begin
      if (resetn) begin
         if (bus.penable && !bus.psel) viol++;
         if (bus.psel && bus.penable && !prev_psel) viol++;
         prev_psel = bus.psel;
         if (bus.psel && !bus.penable) setup_log.push_back({bus.pwrite, bus.paddr, bus.pwdata});
         if (bus.rsp_valid && bus.rsp_ready) rsp_log.push_back({bus.rsp_err, bus.rsp_rdata});
      end else begin
         prev_psel = 1'b0;
      end
   end

   // One command end to end; waitc = stalled ACCESS cycles before pready, negative = never.
   task automatic applyStimulus(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                                input int waitc, input int hold);
      bit         exp_err;
      int         exp_acc;
      logic [7:0] exp_rd;
      int         n;
      int         lat;
      int         acc;
      int         unstable;
      logic [7:0] held_rd;
      logic       held_err;

      exp_err = (waitc < 0) || (waitc >= TIMEOUT);
      exp_acc = exp_err ? TIMEOUT : waitc + 1;
      exp_rd  = (exp_err || wr) ? 8'h00 : model_mem[addr];
      if (!exp_err && wr) model_mem[addr] = wd;

      wait_cfg      = waitc;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wd;
      bus.cmd_valid = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin
         stepCycle();
         n++;
      end
      checkOutput("accept_wait", 32'(n), 32'd0);
      stepCycle();
      bus.cmd_valid = 1'b0;
      checkOutput("setup_phase", 32'({bus.psel, bus.penable}), 32'b10);
      checkOutput("setup_addr", 32'(bus.paddr), 32'(addr));

      lat = 1;
      acc = 0;
      unstable = 0;
      stepCycle();
      while (bus.penable && lat < TIMEOUT + 10) begin
         acc++;
         if (!bus.psel || bus.paddr !== addr || bus.pwdata !== wd || bus.pwrite !== wr) unstable++;
         stepCycle();
         lat++;
      end
      checkOutput("access_cycles", 32'(acc), 32'(exp_acc));
      checkOutput("access_stable", 32'(unstable), 32'd0);
      checkOutput("rsp_latency", 32'(lat), 32'(exp_acc + 1));
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("apb_idle_resp", 32'({bus.psel, bus.penable}), 32'b00);
      checkOutput("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      checkOutput("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
      checkOutput("cmd_ready_resp", 32'(bus.cmd_ready), 32'd0);

      held_rd  = bus.rsp_rdata;
      held_err = bus.rsp_err;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
         stepCycle();
         if (!bus.rsp_valid || bus.rsp_rdata !== held_rd || bus.rsp_err !== held_err ||
             bus.cmd_ready || bus.psel) unstable++;
      end
      if (hold > 0) checkOutput("rsp_hold", 32'(unstable), 32'd0);

      bus.rsp_ready = 1'b1;
      stepCycle();
      bus.rsp_ready = 1'b0;
      checkOutput("rsp_done", 32'({bus.rsp_valid, bus.cmd_ready}), 32'b01);
   endtask

   task automatic applyResetMidTransfer();
      int spurious;
      wait_cfg      = -1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 8'h33;
      bus.cmd_wdata = 8'h00;
      bus.cmd_valid = 1'b1;
      stepCycle();
      bus.cmd_valid = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("rst_pre_access", 32'({bus.psel, bus.penable}), 32'b11);
      #1 resetn = 1'b0;
      #1;
      checkOutput("rst_async_apb", 32'({bus.psel, bus.penable, bus.rsp_valid}), 32'b000);
      checkOutput("rst_async_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("rst_async_paddr", 32'(bus.paddr), 32'd0);
      stepCycle();
      stepCycle();
      resetn = 1'b1;
      spurious = 0;
      for (int i = 0; i < 20; i++) begin
         stepCycle();
         if (bus.rsp_valid || bus.psel) spurious++;
      end
      checkOutput("rst_no_spurious", 32'(spurious), 32'd0);
      checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
   endtask

   task automatic applyBackToBack();
      logic [7:0] a [3];
      logic [7:0] d [3];
      bit         w [3];
      logic [8:0] exp_rsp [3];
      int         n;

      a[0] = 8'h20; w[0] = 1'b1; d[0] = 8'($urandom);
      a[1] = 8'h20; w[1] = 1'b0; d[1] = 8'($urandom);
      a[2] = 8'h21; w[2] = 1'b1; d[2] = 8'($urandom);
      for (int i = 0; i < 3; i++) begin
         if (w[i]) begin
            model_mem[a[i]] = d[i];
            exp_rsp[i] = 9'h000;
         end else begin
            exp_rsp[i] = {1'b0, model_mem[a[i]]};
         end
      end

      setup_log.delete();
      rsp_log.delete();
      wait_cfg      = 0;
      bus.rsp_ready = 1'b1;
      bus.cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.cmd_write = w[i];
         bus.cmd_addr  = a[i];
         bus.cmd_wdata = d[i];
         n = 0;
         while (!bus.cmd_ready && n < 20) begin
            stepCycle();
            n++;
         end
         if (i > 0) checkOutput("b2b_gap", 32'(n), 32'd3);
         stepCycle();
      end
      bus.cmd_valid = 1'b0;
      repeat (6) stepCycle();
      bus.rsp_ready = 1'b0;

      checkOutput("b2b_setups", 32'(setup_log.size()), 32'd3);
      checkOutput("b2b_rsps", 32'(rsp_log.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < setup_log.size()) checkOutput("b2b_setup_order", 32'(setup_log[i]), 32'({w[i], a[i], d[i]}));
         if (i < rsp_log.size()) checkOutput("b2b_rsp_order", 32'(rsp_log[i]), 32'(exp_rsp[i]));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: observed=stuck expected=finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      bit         wr;
      logic [7:0] addr;
      logic [7:0] wd;
      int         r;
      int         waitc;

      for (int i = 0; i < 256; i++) begin
         slave_mem[i] = 8'(i) ^ 8'hA5;
         model_mem[i] = 8'(i) ^ 8'hA5;
      end
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 8'h00;
      bus.cmd_wdata = 8'h00;
      bus.rsp_ready = 1'b0;
      bus.pready    = 1'b0;
      bus.prdata    = 8'h00;

      repeat (3) stepCycle();
      checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("reset_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 32'd0);
      checkOutput("reset_apb_ctrl", 32'({bus.psel, bus.penable, bus.pwrite}), 32'd0);
      checkOutput("reset_apb_data", 32'({bus.paddr, bus.pwdata}), 32'd0);
      resetn = 1'b1;
      stepCycle();

      applyStimulus(1'b1, 8'h12, 8'h3C, 2, 0);
      slave_mem[8'h40] = 8'hFF;
      model_mem[8'h40] = 8'hFF;
      applyStimulus(1'b0, 8'h40, 8'h00, 0, 0);
      applyStimulus(1'b0, 8'h12, 8'h00, 1, 5);
      applyStimulus(1'b0, 8'h55, 8'h00, -1, 0);
      applyStimulus(1'b1, 8'h56, 8'hAA, TIMEOUT - 1, 0);
      applyStimulus(1'b1, 8'h57, 8'hBB, TIMEOUT, 0);
      applyStimulus(1'b0, 8'h56, 8'h00, 0, 0);
      applyStimulus(1'b0, 8'h57, 8'h00, 0, 0);

      applyResetMidTransfer();
      applyBackToBack();

      for (int k = 0; k < 24; k++) begin
         wr    = 1'($urandom_range(0, 1));
         addr  = 8'($urandom_range(0, 7));
         wd    = 8'($urandom);
         r     = int'($urandom_range(0, 9));
         waitc = (r < 7) ? int'($urandom_range(0, 4)) : (r == 7) ? TIMEOUT - 1 : (r == 8) ? TIMEOUT : -1;
         applyStimulus(wr, addr, wd, waitc, int'($urandom_range(0, 3)));
      end

      checkOutput("phase_order", 32'(viol), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
